// File: rtl/axis_depacketizer_pacer_if.sv
// AXI-Stream bundle used for both the packet input (slave side) and the paced
// sample output (master side) of axis_depacketizer_pacer.
interface axis_depacketizer_pacer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_depacketizer_pacer.sv
// Buffers one SMPLS-sample AXIS packet, then replays it one sample per PACE_CLKS
// toward a DAC sink. Define AXIS_DEPKT_TLAST_CHECK_EN to enable tlast position checking.
//
// state | meaning
// LOAD  | s_axis tready high, packet beats written into sample_buf
// PLAY  | s_axis stalled, sample_buf replayed on m_axis at the pace rate
module axis_depacketizer_pacer #(
  parameter int ACLK        = 100_000_000,
  parameter int SMPLS       = 30,
  parameter int FSMPL       = 200,
  parameter int DATA_WIDTH  = 16,
  parameter int INTRPT_CLKS = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axis_depacketizer_pacer_if.slave  s_axis,
  axis_depacketizer_pacer_if.master m_axis,
  output logic                      m_axis_interrupt,
  output logic                      late_err,
  output logic                      pkt_err
);
  localparam int PACE_CLKS = ACLK / FSMPL;
  localparam int IW = $clog2(SMPLS);
  localparam int PW = $clog2(PACE_CLKS);
  localparam int QW = $clog2(INTRPT_CLKS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(SMPLS - 1);
  localparam logic [PW-1:0] PACE_TOP = PW'(PACE_CLKS - 1);
  localparam logic [QW-1:0] INTR_LEN = QW'(INTRPT_CLKS);

  typedef enum logic {LOAD, PLAY} state_t;

  state_t                state;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [IW-1:0]         rd_next;
  logic [PW-1:0]         pace_cnt;
  logic [QW-1:0]         intr_cnt;
  logic                  s_ready_r;
  logic                  m_valid_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic [DATA_WIDTH-1:0] sample_buf [SMPLS];

  logic s_fire;
  logic m_fire;
  logic tick;
  logic early_tlast;
  logic missing_tlast;

  assign s_axis.tready = s_ready_r;
  assign m_axis.tvalid = m_valid_r;
  assign m_axis.tdata  = m_data_r;
  assign m_axis.tlast  = 1'b0;

  assign s_fire  = (state == LOAD) && s_axis.tvalid && s_ready_r;
  assign m_fire  = m_valid_r && m_axis.tready;
  assign tick    = (pace_cnt == '0);
  assign rd_next = m_fire ? rd_idx + 1'b1 : rd_idx;

`ifdef AXIS_DEPKT_TLAST_CHECK_EN
  assign early_tlast   = s_axis.tlast && (wr_idx != LAST_IDX);
  assign missing_tlast = !s_axis.tlast && (wr_idx == LAST_IDX);
`else
  logic unused_tlast;
  assign unused_tlast  = s_axis.tlast;
  assign early_tlast   = 1'b0;
  assign missing_tlast = 1'b0;
`endif

  // Packet storage carries no reset; its contents are rewritten before every replay.
  always_ff @(posedge aclk) begin
    if (aresetn && s_fire && !early_tlast)
      sample_buf[wr_idx] <= s_axis.tdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state            <= LOAD;
      wr_idx           <= '0;
      rd_idx           <= '0;
      pace_cnt         <= '0;
      s_ready_r        <= 1'b0;
      m_valid_r        <= 1'b0;
      m_data_r         <= '0;
      late_err         <= 1'b0;
      pkt_err          <= 1'b0;
      intr_cnt         <= INTR_LEN;
      m_axis_interrupt <= 1'b0;
    end else begin
      if (intr_cnt != '0) begin
        m_axis_interrupt <= 1'b1;
        intr_cnt         <= intr_cnt - 1'b1;
      end else begin
        m_axis_interrupt <= 1'b0;
      end

      case (state)
        LOAD: begin
          s_ready_r <= 1'b1;
          if (s_fire) begin
            if (early_tlast) begin
              pkt_err <= 1'b1;
              wr_idx  <= '0;
            end else if (wr_idx == LAST_IDX) begin
              state     <= PLAY;
              wr_idx    <= '0;
              s_ready_r <= 1'b0;
              pace_cnt  <= PACE_TOP;
              if (missing_tlast)
                pkt_err <= 1'b1;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end

        PLAY: begin
          s_ready_r <= 1'b0;
          pace_cnt  <= tick ? PACE_TOP : pace_cnt - 1'b1;
          if (m_fire && (rd_idx == LAST_IDX)) begin
            state            <= LOAD;
            rd_idx           <= '0;
            m_valid_r        <= 1'b0;
            s_ready_r        <= 1'b1;
            m_axis_interrupt <= 1'b1;
            intr_cnt         <= INTR_LEN - 1'b1;
          end else begin
            rd_idx <= rd_next;
            // A tick only counts as late if the sink is still holding off this cycle.
            if (tick) begin
              if (m_valid_r && !m_axis.tready) begin
                late_err <= 1'b1;
              end else begin
                m_valid_r <= 1'b1;
                m_data_r  <= sample_buf[rd_next];
              end
            end else if (m_fire) begin
              m_valid_r <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_depacketizer_pacer.sv
// Self-checking bench for axis_depacketizer_pacer: packets are written, replay is
// compared cycle by cycle against a pace/handshake reference model.
module tb_axis_depacketizer_pacer;
  localparam int SMPLS       = 4;
  localparam int ACLK        = 1000;
  localparam int FSMPL       = 100;
  localparam int DW          = 16;
  localparam int INTRPT_CLKS = 3;
  localparam int PACE        = ACLK / FSMPL;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic m_axis_interrupt;
  logic late_err;
  logic pkt_err;

  axis_depacketizer_pacer_if #(.DATA_WIDTH(DW)) s_axis ();
  axis_depacketizer_pacer_if #(.DATA_WIDTH(DW)) m_axis ();

  axis_depacketizer_pacer #(
    .ACLK        (ACLK),
    .SMPLS       (SMPLS),
    .FSMPL       (FSMPL),
    .DATA_WIDTH  (DW),
    .INTRPT_CLKS (INTRPT_CLKS)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis           (s_axis),
    .m_axis           (m_axis),
    .m_axis_interrupt (m_axis_interrupt),
    .late_err         (late_err),
    .pkt_err          (pkt_err)
  );

  always #5 aclk = ~aclk;

  int            vectors = 0;
  int            errors  = 0;
  logic [DW-1:0] pkt [SMPLS];
  logic [DW-1:0] last_data;
  bit            model_late;

  task automatic apply_reset();
    @(posedge aclk); #1;
    aresetn       = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    model_late = 1'b0;
    last_data  = '0;
    @(negedge aclk);
    vectors++;
    if ({s_axis.tready, m_axis.tvalid, late_err, pkt_err, m_axis_interrupt} !== 5'b0 ||
        m_axis.tdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_values got s_rdy/m_vld/late/pkt/irq=%b%b%b%b%b tdata=%h want 00000 tdata=0000",
               s_axis.tready, m_axis.tvalid, late_err, pkt_err, m_axis_interrupt, m_axis.tdata);
    end
    for (int k = 1; k <= INTRPT_CLKS + 2; k++) begin
      @(negedge aclk);
      vectors++;
      if (m_axis_interrupt !== (k <= INTRPT_CLKS) || s_axis.tready !== 1'b1 || m_axis.tvalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_release k=%0d got irq=%b s_rdy=%b m_vld=%b want irq=%b s_rdy=1 m_vld=0",
                 k, m_axis_interrupt, s_axis.tready, m_axis.tvalid, (k <= INTRPT_CLKS));
      end
    end
  endtask

  // Leaves the caller at posedge+1 of the first PLAY cycle when the packet completes.
  task automatic send_packet(input int tlast_pos, input bit hold_valid);
    for (int i = 0; i < SMPLS; i++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge aclk); #1;
        s_axis.tvalid = 1'b0;
      end
      @(posedge aclk); #1;
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = pkt[i];
      s_axis.tlast  = (i == tlast_pos);
      @(negedge aclk);
      vectors++;
      if (s_axis.tready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready beat=%0d got s_rdy=%b want 1", i, s_axis.tready);
      end
    end
    @(posedge aclk); #1;
    s_axis.tlast = 1'b0;
    if (hold_valid) s_axis.tdata = 16'hDEAD;
    else            s_axis.tvalid = 1'b0;
  endtask

  // mode 0: sink always ready; 1: sink stalls 15 cycles on the first sample; 2: random sink.
  task automatic play_check(input int mode, input int stop_after);
    bit            pend      = 1'b0;
    int            issued    = 0;
    int            delivered = 0;
    logic          tr;
    bit            tck;
    logic [DW-1:0] cur       = last_data;
    for (int c = 0; c < 40 * PACE && delivered < stop_after; c++) begin
      if (c > 0) begin @(posedge aclk); #1; end
      case (mode)
        0:       tr = 1'b1;
        1:       tr = !(c >= PACE && c < PACE + 15);
        default: tr = ($urandom_range(0, 3) == 0);
      endcase
      m_axis.tready = tr;
      @(negedge aclk);
      vectors++;
      if (m_axis.tvalid !== pend || m_axis.tdata !== cur) begin
        errors++;
        $display("FAIL play_out c=%0d got tvalid=%b tdata=%h want tvalid=%b tdata=%h",
                 c, m_axis.tvalid, m_axis.tdata, pend, cur);
      end
      vectors++;
      if (late_err !== model_late) begin
        errors++;
        $display("FAIL play_late c=%0d got late_err=%b want %b", c, late_err, model_late);
      end
      vectors++;
      if (s_axis.tready !== 1'b0 || m_axis_interrupt !== 1'b0) begin
        errors++;
        $display("FAIL play_idle c=%0d got s_rdy=%b irq=%b want 0 0", c, s_axis.tready, m_axis_interrupt);
      end
      // Reference: sample slots every PACE cycles, first slot closes at cycle PACE-1.
      tck = ((c % PACE) == PACE - 1);
      if (pend && tr) begin
        delivered++;
        pend = 1'b0;
      end
      if (tck && delivered < SMPLS) begin
        if (pend) model_late = 1'b1;
        else if (issued < SMPLS) begin
          pend = 1'b1;
          cur  = pkt[issued];
          issued++;
        end
      end
    end
    last_data = cur;
    vectors++;
    if (delivered != stop_after) begin
      errors++;
      $display("FAIL play_timeout got delivered=%0d want %0d", delivered, stop_after);
    end
    if (stop_after == SMPLS) begin
      for (int k = 1; k <= INTRPT_CLKS + 1; k++) begin
        @(posedge aclk); #1;
        s_axis.tvalid = 1'b0;
        @(negedge aclk);
        vectors++;
        if (s_axis.tready !== 1'b1 || m_axis.tvalid !== 1'b0 ||
            m_axis_interrupt !== (k <= INTRPT_CLKS) || m_axis.tdata !== cur) begin
          errors++;
          $display("FAIL reload k=%0d got s_rdy=%b m_vld=%b irq=%b tdata=%h want 1 0 %b %h",
                   k, s_axis.tready, m_axis.tvalid, m_axis_interrupt, m_axis.tdata,
                   (k <= INTRPT_CLKS), cur);
        end
      end
    end
  endtask

  task automatic load_fixed();
    pkt[0] = 16'h0011; pkt[1] = 16'h0022; pkt[2] = 16'h0033; pkt[3] = 16'h0044;
  endtask

  task automatic load_random();
    for (int i = 0; i < SMPLS; i++) pkt[i] = DW'($urandom);
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_basic_play();
    load_fixed();
    send_packet(SMPLS - 1, 1'b0);
    play_check(0, SMPLS);
  endtask

  task automatic test_late_stall();
    load_fixed();
    send_packet(SMPLS - 1, 1'b0);
    play_check(1, SMPLS);
    vectors++;
    if (late_err !== 1'b1) begin
      errors++;
      $display("FAIL late_sticky got late_err=%b want 1", late_err);
    end
  endtask

  task automatic test_tlast();
`ifdef AXIS_DEPKT_TLAST_CHECK_EN
    @(posedge aclk); #1;
    s_axis.tvalid = 1'b1; s_axis.tdata = 16'h00A1; s_axis.tlast = 1'b0;
    @(posedge aclk); #1;
    s_axis.tdata = 16'h00A2; s_axis.tlast = 1'b1;
    @(posedge aclk); #1;
    s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    @(negedge aclk);
    vectors++;
    if (pkt_err !== 1'b1 || s_axis.tready !== 1'b1 || m_axis_interrupt !== 1'b0 || m_axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL tlast_early got pkt_err=%b s_rdy=%b irq=%b m_vld=%b want 1 1 0 0",
               pkt_err, s_axis.tready, m_axis_interrupt, m_axis.tvalid);
    end
    load_random();
    send_packet(SMPLS - 1, 1'b0);
    play_check(0, SMPLS);
`else
    load_random();
    send_packet(1, 1'b0);
    play_check(0, SMPLS);
    vectors++;
    if (pkt_err !== 1'b0) begin
      errors++;
      $display("FAIL tlast_ignored got pkt_err=%b want 0", pkt_err);
    end
`endif
  endtask

  task automatic test_reset_mid_play();
    load_random();
    send_packet(SMPLS - 1, 1'b0);
    play_check(0, 2);
    apply_reset();
    load_random();
    send_packet(SMPLS - 1, 1'b0);
    play_check(0, SMPLS);
  endtask

  task automatic test_random_packets();
    for (int p = 0; p < 4; p++) begin
      load_random();
      send_packet(SMPLS - 1, 1'b0);
      play_check(2, SMPLS);
    end
  endtask

  task automatic test_tvalid_in_play();
    load_random();
    send_packet(SMPLS - 1, 1'b1);
    play_check(0, SMPLS);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b0;
    model_late    = 1'b0;
    last_data     = '0;
    test_reset();
    test_basic_play();
    test_late_stall();
    test_tlast();
    test_reset_mid_play();
    test_random_packets();
    test_tvalid_in_play();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
